axi_w_dest_router: RTL

Write-data-channel stage placed directly downstream of the AW address decoder in the AXI node slave port.
- Queues the one-hot destination vectors that the AW decoder pushes for each accepted write address.
- Steers W beats of each burst to the matching initiator port, then pops the destination on the last beat.
- When the AW decoder enters error handling, sinks (accepts and discards) the W burst of the errored transaction and signals its completion.

---
 rtl/axi_w_dest_router.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axi_w_dest_router.sv
// axi_w_dest_router
//   W-channel stage behind the AW decoder. Queues one-hot destinations pushed
//   per accepted AW, steers each W burst to its initiator port and pops the
//   destination on the last beat. While the AW decoder handles an error, the
//   errored burst is sunk and its completion is pulsed.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   push_DEST_i, DEST_i         destination push from the AW decoder
//   grant_FIFO_DEST_o           destination FIFO not full
//   wvalid_i, wlast_i, wready_o W beat handshake on the slave side
//   wvalid_o, wready_i          per-initiator-port W handshake
//   handle_error_i              sink request for the errored W burst
//   wdata_error_completed_o     one-cycle pulse when the errored burst is sunk
module axi_w_dest_router #(
    parameter int unsigned N_INIT_PORT    = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned LOG_FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_DEST_i,
    input  logic [N_INIT_PORT-1:0] DEST_i,
    output logic                   grant_FIFO_DEST_o,
    input  logic                   wvalid_i,
    input  logic                   wlast_i,
    output logic                   wready_o,
    output logic [N_INIT_PORT-1:0] wvalid_o,
    input  logic [N_INIT_PORT-1:0] wready_i,
    input  logic                   handle_error_i,
    output logic                   wdata_error_completed_o
);

    typedef enum logic [1:0] {
        ROUTE     = 2'd0,
        ERR_DRAIN = 2'd1,
        ERR_WAIT  = 2'd2
    } state_e;

    localparam logic [LOG_FIFO_DEPTH:0] FULL_CNT = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);

    state_e state_q, state_d;

    logic [N_INIT_PORT-1:0]    mem_q [FIFO_DEPTH];
    logic [LOG_FIFO_DEPTH-1:0] wptr_q, wptr_d;
    logic [LOG_FIFO_DEPTH-1:0] rptr_q, rptr_d;
    logic [LOG_FIFO_DEPTH:0]   count_q, count_d;

    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [N_INIT_PORT-1:0] head;

    assign empty             = (count_q == '0);
    assign grant_FIFO_DEST_o = (count_q != FULL_CNT);
    assign head              = mem_q[rptr_q];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ROUTE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            // Queued bursts precede the errored one, so drain only once empty.
            ROUTE:     if (handle_error_i && empty)  state_d = ERR_DRAIN;
            ERR_DRAIN: if (wvalid_i && wlast_i)      state_d = ERR_WAIT;
            ERR_WAIT:  if (!handle_error_i)          state_d = ROUTE;
            default:                                 state_d = ROUTE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        wvalid_o                = '0;
        wready_o                = 1'b0;
        wdata_error_completed_o = 1'b0;
        case (state_q)
            ROUTE: begin
                if (!empty) begin
                    wvalid_o = head & {N_INIT_PORT{wvalid_i}};
                    wready_o = |(head & wready_i);
                end
            end
            ERR_DRAIN: begin
                wready_o                = 1'b1;
                wdata_error_completed_o = wvalid_i & wlast_i;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Destination FIFO
    // ------------------------------------------------------------------
    always_comb begin
        pop  = (state_q == ROUTE) & ~empty & wvalid_i & wready_o & wlast_i;
        // A pop in the same cycle frees the slot, so a push while full is
        // taken when it coincides with a pop even though grant reads 0.
        push = push_DEST_i & (grant_FIFO_DEST_o | pop);

        wptr_d  = push ? wptr_q + LOG_FIFO_DEPTH'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + LOG_FIFO_DEPTH'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (LOG_FIFO_DEPTH+1)'(1);
            2'b01:   count_d = count_q - (LOG_FIFO_DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wptr_q] <= DEST_i;
            end
        end
    end

endmodule
